// File: rtl/hwpe_ctrl_package.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_ctrl_package
// Brief    : Shared constants and types for the HWPE microcode loop engine.
// Revision : 1.0 - initial release
// ============================================================================
package hwpe_ctrl_package;

    localparam int UCODE_NB_LOOPS  = 6;
    localparam int UCODE_NB_REG    = 4;
    localparam int UCODE_NB_RO_REG = 28;
    localparam int UCODE_REG_WIDTH = 32;
    localparam int UCODE_CNT_WIDTH = 12;
    localparam int UCODE_LENGTH    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        VALID = 2'd2,
        DONE  = 2'd3
    } uloop_state_t;

    // Index width that never collapses to zero bits for single-entry sets.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hwpe_ctrl_uloop_cnt.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_ctrl_uloop_cnt
// Brief    : Loop index nest; finds the lowest non-exhausted loop and steps it.
// Revision : 1.0 - initial release
// ============================================================================
module hwpe_ctrl_uloop_cnt
    import hwpe_ctrl_package::*;
#(
    parameter int NB_LOOPS  = UCODE_NB_LOOPS,
    parameter int CNT_WIDTH = UCODE_CNT_WIDTH,
    parameter int LVW       = clog2_min1(NB_LOOPS)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          step_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0] range_i,
    output logic [NB_LOOPS*CNT_WIDTH-1:0] idx_o,
    output logic [LVW-1:0]                lvl_o,
    output logic                          found_o
);

    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] idx_q;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] w_range;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] w_lim;

    assign w_range = range_i;
    assign idx_o   = idx_q;

    // A zero trip count behaves as a single iteration, so its last index is 0.
    always_comb begin
        for (int l = 0; l < NB_LOOPS; l++) begin
            w_lim[l] = (w_range[l] == '0) ? '0 : w_range[l] - 1'b1;
        end
    end

    always_comb begin
        found_o = 1'b0;
        lvl_o   = '0;
        for (int l = NB_LOOPS - 1; l >= 0; l--) begin
            if (idx_q[l] < w_lim[l]) begin
                found_o = 1'b1;
                lvl_o   = LVW'(l);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q <= '0;
        end else if (step_i) begin
            for (int l = 0; l < NB_LOOPS; l++) begin
                if (LVW'(l) < lvl_o) begin
                    idx_q[l] <= '0;
                end else if (LVW'(l) == lvl_o) begin
                    idx_q[l] <= idx_q[l] + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hwpe_ctrl_uloop_gen.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_ctrl_uloop_gen
// Brief    : Parametrised nested-loop microcode engine with ready/valid output.
//            Define HWPE_UCODE_SNAPSHOT_EN to shadow the configuration inputs.
// Revision : 1.0 - initial release
// ============================================================================
module hwpe_ctrl_uloop_gen
    import hwpe_ctrl_package::*;
#(
    parameter int NB_LOOPS  = UCODE_NB_LOOPS,
    parameter int NB_REG    = UCODE_NB_REG,
    parameter int NB_RO_REG = UCODE_NB_RO_REG,
    parameter int REG_WIDTH = UCODE_REG_WIDTH,
    parameter int CNT_WIDTH = UCODE_CNT_WIDTH,
    parameter int LENGTH    = UCODE_LENGTH,
    parameter int OP_W      = 1 + 2*$clog2(NB_RO_REG)
) (
    input  logic                                                    clk_i,
    input  logic                                                    rst_i,
    input  logic                                                    clear_i,
    input  logic                                                    req_i,
    output logic                                                    ready_o,
    input  logic [NB_LOOPS*($clog2(LENGTH)+$clog2(LENGTH+1))-1:0]   loops_i,
    input  logic [LENGTH*OP_W-1:0]                                  code_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0]                           range_i,
    input  logic [NB_RO_REG*REG_WIDTH-1:0]                          ro_reg_i,
    input  logic [$clog2(NB_LOOPS)-1:0]                             accum_loop_i,
    output logic                                                    valid_o,
    input  logic                                                    ready_i,
    output logic [NB_REG*REG_WIDTH-1:0]                             offs_o,
    output logic [NB_LOOPS*CNT_WIDTH-1:0]                           idx_o,
    output logic                                                    accum_o,
    output logic                                                    done_o
);

    localparam int AW  = $clog2(LENGTH);
    localparam int NW  = $clog2(LENGTH+1);
    localparam int LW  = AW + NW;
    localparam int LVW = clog2_min1(NB_LOOPS);
    localparam int RIW = clog2_min1(NB_REG);
    localparam int ABW = (OP_W - 1) / 2;
    localparam int ALW = $clog2(NB_LOOPS);

    logic [NB_LOOPS-1:0][LW-1:0]          w_loops;
    logic [LENGTH-1:0][OP_W-1:0]          w_code;
    logic [NB_LOOPS*CNT_WIDTH-1:0]        w_range;
    logic [ALW-1:0]                       w_accum_loop;
    logic [NB_RO_REG-1:0][REG_WIDTH-1:0]  w_ro;

    uloop_state_t                         state_q;
    logic                                 started_q, valid_q, ready_q, done_q;
    logic [AW-1:0]                        pc_q;
    logic [NW-1:0]                        cnt_q;
    logic [NB_REG-1:0][REG_WIDTH-1:0]     offs_q;

    logic [NB_LOOPS*CNT_WIDTH-1:0]        w_idx;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]   w_idx_a;
    logic [LVW-1:0]                       w_lvl;
    logic                                 w_found, w_accept, w_step, w_soft_rst;
    logic [AW-1:0]                        w_lvl_addr;
    logic [NW-1:0]                        w_lvl_nb;
    logic [OP_W-1:0]                      w_op;
    logic                                 w_sel;
    logic [ABW-1:0]                       w_a, w_b;
    logic [RIW-1:0]                       w_dst, w_src;
    logic [REG_WIDTH-1:0]                 w_ro_val, w_addend;
    logic                                 w_accum;

`ifdef HWPE_UCODE_SNAPSHOT_EN
    logic [NB_LOOPS-1:0][LW-1:0]          loops_q;
    logic [LENGTH-1:0][OP_W-1:0]          code_q;
    logic [NB_LOOPS*CNT_WIDTH-1:0]        range_q;
    logic [ALW-1:0]                       accum_loop_q;

    assign w_loops      = loops_q;
    assign w_code       = code_q;
    assign w_range      = range_q;
    assign w_accum_loop = accum_loop_q;
`else
    assign w_loops      = loops_i;
    assign w_code       = code_i;
    assign w_range      = range_i;
    assign w_accum_loop = accum_loop_i;
`endif

    assign w_ro       = ro_reg_i;
    assign w_soft_rst = rst_i | clear_i;
    assign w_accept   = req_i & ready_q;
    assign w_step     = w_accept & started_q & w_found;

    hwpe_ctrl_uloop_cnt #(
        .NB_LOOPS  (NB_LOOPS),
        .CNT_WIDTH (CNT_WIDTH),
        .LVW       (LVW)
    ) i_cnt (
        .clk_i   (clk_i),
        .rst_i   (w_soft_rst),
        .step_i  (w_step),
        .range_i (w_range),
        .idx_o   (w_idx),
        .lvl_o   (w_lvl),
        .found_o (w_found)
    );

    assign w_lvl_addr = w_loops[w_lvl][LW-1 -: AW];
    assign w_lvl_nb   = w_loops[w_lvl][NW-1:0];

    // Op word is {op_sel, a, b}; register indices wrap onto the NB_REG file.
    assign w_op     = w_code[pc_q];
    assign w_sel    = w_op[OP_W-1];
    assign w_a      = w_op[OP_W-2 -: ABW];
    assign w_b      = w_op[ABW-1:0];
    assign w_dst    = RIW'(32'(w_a) % NB_REG);
    assign w_src    = RIW'(32'(w_b) % NB_REG);
    assign w_ro_val = (32'(w_b) < NB_RO_REG) ? w_ro[w_b] : '0;
    assign w_addend = w_sel ? w_ro_val : offs_q[w_src];

    assign w_idx_a = w_idx;
    always_comb begin
        w_accum = 1'b1;
        for (int k = 0; k < NB_LOOPS; k++) begin
            if ((32'(k) < 32'(w_accum_loop)) && (w_idx_a[k] != '0)) begin
                w_accum = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_soft_rst) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            pc_q      <= '0;
            cnt_q     <= '0;
            offs_q    <= '0;
`ifdef HWPE_UCODE_SNAPSHOT_EN
            loops_q      <= '0;
            code_q       <= '0;
            range_q      <= '0;
            accum_loop_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        ready_q <= 1'b0;
                        if (!started_q) begin
                            started_q <= 1'b1;
                            state_q   <= VALID;
                            valid_q   <= 1'b1;
`ifdef HWPE_UCODE_SNAPSHOT_EN
                            loops_q      <= loops_i;
                            code_q       <= code_i;
                            range_q      <= range_i;
                            accum_loop_q <= accum_loop_i;
`endif
                        end else if (w_found) begin
                            pc_q  <= w_lvl_addr;
                            cnt_q <= w_lvl_nb;
                            if (w_lvl_nb == '0) begin
                                state_q <= VALID;
                                valid_q <= 1'b1;
                            end else begin
                                state_q <= EXEC;
                            end
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    offs_q[w_dst] <= offs_q[w_dst] + w_addend;
                    pc_q          <= (32'(pc_q) == LENGTH - 1) ? '0 : pc_q + 1'b1;
                    cnt_q         <= cnt_q - 1'b1;
                    if (cnt_q == NW'(1)) begin
                        state_q <= VALID;
                        valid_q <= 1'b1;
                    end
                end
                VALID: begin
                    if (ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign offs_o  = offs_q;
    assign idx_o   = w_idx;
    assign accum_o = w_accum;

endmodule
`default_nettype wire
